// File: rtl/ecc_pkg.sv
// Shared types, index maps and Hamming(12,8) helpers for ecc_mem_ctrl.
// Codeword index k holds Hamming position k+1; parity sits at 0,1,3,7.
package ecc_pkg;

  typedef logic [11:0] cw_t;
  typedef logic [7:0]  byte_t;
  typedef logic [3:0]  syn_t;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDAT,
    SCRUB
  } state_t;

  localparam int unsigned PAR_IDX [4] = '{0, 1, 3, 7};
  localparam int unsigned DAT_IDX [8] =
    '{2, 4, 5, 6, 8, 9, 10, 11};

  function automatic syn_t ham_syn(cw_t c);
    syn_t s;
    s = '0;
    for (int k = 0; k < 12; k++)
      if (c[k]) s = s ^ syn_t'(k + 1);
    return s;
  endfunction

  // Parity bits are zero while data is placed, so the
  // partial syndrome is exactly the parity vector.
  function automatic cw_t ham_enc(byte_t d);
    cw_t  c;
    syn_t s;
    c = '0;
    for (int i = 0; i < 8; i++)
      c[DAT_IDX[i]] = d[i];
    s = ham_syn(c);
    for (int j = 0; j < 4; j++)
      c[PAR_IDX[j]] = s[j];
    return c;
  endfunction

  function automatic cw_t ham_fix(cw_t c, syn_t s);
    cw_t f;
    f = c;
    if (s != '0 && s <= 4'd12)
      f[s - 4'd1] = ~c[s - 4'd1];
    return f;
  endfunction

  function automatic byte_t ham_dat(cw_t c);
    byte_t d;
    for (int i = 0; i < 8; i++)
      d[i] = c[DAT_IDX[i]];
    return d;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr=0 favours port A, ptr=1 port B.
// The pointer flips to the non-granted port on every accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (ptr)
      gnt = req[1] ? 2'b10 : {1'b0, req[0]};
    else
      gnt = req[0] ? 2'b01 : {req[1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (accept && |gnt)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// Two-port arbitrated controller for a Hamming(12,8) protected RAM.
// Define ECC_SCRUB_WB_EN to write corrected codewords back after reads.
module ecc_mem_ctrl
  import ecc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_a,
  input  logic             i_req_b,
  input  logic             i_we_a,
  input  logic             i_we_b,
  input  logic [AW-1:0]    i_addr_a,
  input  logic [AW-1:0]    i_addr_b,
  input  logic [7:0]       i_wdata_a,
  input  logic [7:0]       i_wdata_b,
  output logic             o_gnt_a,
  output logic             o_gnt_b,
  output logic             o_rvalid_a,
  output logic             o_rvalid_b,
  output logic [7:0]       o_rdata_a,
  output logic [7:0]       o_rdata_b,
  output logic             o_cerr_a,
  output logic             o_cerr_b,
  output logic             o_uerr_a,
  output logic             o_uerr_b,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [11:0]      o_mem_wdata,
  input  logic [11:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_cerr_cnt
);

  state_t        state, nxt;
  logic [1:0]    gnt;
  logic          accept;
  logic          we_q, port_q, rd_pend;
  logic [AW-1:0] addr_q;
  byte_t         wdata_q;
  syn_t          syn;
  cw_t           fixed;
  logic          cerr, uerr, scrub_go, cmd;

  rr_arb2 u_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    ({i_req_b, i_req_a}),
    .accept (accept),
    .gnt    (gnt)
  );

  // RAM data lands while the FSM is already back in IDLE;
  // rd_pend marks that cycle so decode overlaps the next grant.
  assign syn   = ham_syn(i_mem_rdata);
  assign fixed = ham_fix(i_mem_rdata, syn);
  assign cerr  = rd_pend && syn != '0 && syn <= 4'd12;
  assign uerr  = rd_pend && syn > 4'd12;
  assign cmd   = state == CMD;

`ifdef ECC_SCRUB_WB_EN
  assign scrub_go = cerr;
`else
  assign scrub_go = 1'b0;
`endif

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (scrub_go) begin
          nxt = SCRUB;
        end else if (|gnt) begin
          nxt    = CMD;
          accept = 1'b1;
        end
      end
      CMD:  nxt = we_q ? IDLE : RDAT;
      RDAT: nxt = IDLE;
`ifdef ECC_SCRUB_WB_EN
      SCRUB: begin
        nxt = IDLE;
        if (|gnt) begin
          nxt    = CMD;
          accept = 1'b1;
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      port_q      <= 1'b0;
      rd_pend     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      o_gnt_a     <= 1'b0;
      o_gnt_b     <= 1'b0;
      o_rvalid_a  <= 1'b0;
      o_rvalid_b  <= 1'b0;
      o_rdata_a   <= '0;
      o_rdata_b   <= '0;
      o_cerr_a    <= 1'b0;
      o_cerr_b    <= 1'b0;
      o_uerr_a    <= 1'b0;
      o_uerr_b    <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cerr_cnt  <= '0;
    end else begin
      state   <= nxt;
      o_gnt_a <= accept & gnt[0];
      o_gnt_b <= accept & gnt[1];
      if (accept) begin
        port_q  <= gnt[1];
        we_q    <= gnt[1] ? i_we_b    : i_we_a;
        addr_q  <= gnt[1] ? i_addr_b  : i_addr_a;
        wdata_q <= gnt[1] ? i_wdata_b : i_wdata_a;
      end
      rd_pend     <= state == RDAT;
      o_mem_en    <= cmd | scrub_go;
      o_mem_we    <= (cmd & we_q) | scrub_go;
      o_mem_addr  <= (cmd | scrub_go) ? addr_q : '0;
      o_mem_wdata <= scrub_go ? fixed
                   : cmd ? ham_enc(wdata_q) : '0;
      o_rvalid_a  <= rd_pend & ~port_q;
      o_rvalid_b  <= rd_pend & port_q;
      if (rd_pend && !port_q) begin
        o_rdata_a <= ham_dat(fixed);
        o_cerr_a  <= cerr;
        o_uerr_a  <= uerr;
      end
      if (rd_pend && port_q) begin
        o_rdata_b <= ham_dat(fixed);
        o_cerr_b  <= cerr;
        o_uerr_b  <= uerr;
      end
      if (cerr && !(&o_cerr_cnt))
        o_cerr_cnt <= o_cerr_cnt + CNT_W'(1);
    end
  end

endmodule
